mem_access_ctrl: RTL
====================

# mem_access_ctrl

Initiator-side controller that sits between the MEM pipeline stage and the data `Memory` block. It turns a stage-level read or write request into a timed, multi-cycle access on the memory port. While the access is in flight it holds the pipeline with `stall`, and it returns registered read data. It is the counterpart of the memory responder: it owns address translation, strobe timing and wait-state counting, so the memory itself stays a plain synchronous array.

## Interface
- `ADDR_W`, 32, width of the stage-side byte address and the memory-side word index
- `DATA_W`, 32, data width
- `BASE_ADDR`, 1024, byte address mapped to memory word 0
- `DEPTH`, 64, number of memory words
- `WAIT_CYCLES`, 4, memory access cycles per request (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_read`  in  1  stage read request, held until `stall` drops
- `req_write`  in  1  stage write request, held until `stall` drops
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  write data
- `stall`  out  1  pipeline freeze
- `rdata`  out  DATA_W  registered read data, valid in the DONE cycle
- `addr_err`  out  1  one-cycle pulse: request was out of range
- `mem_addr`  out  ADDR_W  word index to memory
- `mem_wdata`  out  DATA_W  write data to memory
- `mem_read`  out  1  memory read enable
- `mem_write`  out  1  memory write strobe
- `mem_rdata`  in  DATA_W  memory read data, combinational from `mem_addr`

## Operation
- FSM states:
  - IDLE: if `req_read|req_write`, latch op, word index and data. If in range → ACCESS, counter=0. Else → DONE with the error flag set.
  - ACCESS: counter increments each cycle. At counter==WAIT_CYCLES-1, capture `mem_rdata` into `rdata` (reads only) → DONE.
  - DONE: → IDLE unconditionally.
- Word index = (`req_addr` − BASE_ADDR) >> 2. Bits [1:0] are ignored.
- Out of range: `req_addr` < BASE_ADDR or index ≥ DEPTH. No memory strobes are issued, `rdata`=0, `addr_err`=1 in DONE.
- Write has priority if both requests are asserted.
- `stall` = (`req_read|req_write`) && state≠DONE. This is combinational, so it rises in the request cycle itself.
- `mem_addr` and `mem_wdata` are driven from latched registers only, so stage inputs changing mid-access are ignored.
- `mem_read` is high during every ACCESS cycle of a read.
- `mem_write` is high only in the final ACCESS cycle of a write: one write per request.
- A request dropped mid-access does not abort it; the access runs to DONE, so writes are never torn.
- Reset mid-access: strobes drop asynchronously, FSM → IDLE, no write is committed unless the strobe edge has already occurred.
- Reset values: `stall`=0 (with no request), `rdata`=0, `addr_err`=0, `mem_addr`=0, `mem_wdata`=0, `mem_read`=0, `mem_write`=0, state IDLE, counter 0.

## Timing
- Cycle 0 is the cycle the request is seen in IDLE.
- In range: ACCESS in cycles 1..WAIT_CYCLES, DONE in cycle WAIT_CYCLES+1. `stall` is high in cycles 0..WAIT_CYCLES.
- With the defaults, each access takes 6 cycles and stalls for 5.
- Out of range: DONE in cycle 1, `stall` high in cycle 0 only.
- The pipeline advances on the DONE edge. A back-to-back request is seen in IDLE in the following cycle, giving a one-cycle bubble with no strobes.
- `rdata` holds its value until the next read's capture; `addr_err` is a one-cycle pulse.

## Structure
- Package `mem_ctrl_pkg` holds:
  - state enum (IDLE, ACCESS, DONE)
  - op encoding (NONE, READ, WRITE)
  - default parameter constants
  - index-translation function
- Sub-module `mem_wait_counter`: clear/enable up-counter with a terminal-count flag at WAIT_CYCLES-1. It is instantiated once.
- Top level contains the FSM, latch registers and output decode.

## Test plan
- Reset with `req_*`=0 → every output 0. Pulse `rst` low asynchronously between edges → outputs clear immediately.
- Write 1024, data 2 → `stall` high cycles 0–4. `mem_write` high only in cycle 4, with `mem_addr`=0 and `mem_wdata`=2. `stall` low in cycle 5.
- Writes 1024←2 and 1028←3, then reads 1024 and 1028 → `rdata`=2 in the first read's DONE and 3 in the second. `mem_read` high for 4 cycles each. 1025 reads word 0.
- Read 2024 (index 250 ≥ 64) → `stall` high in cycle 0 only. `addr_err`=1 and `rdata`=0 in cycle 1. No `mem_read` or `mem_write`.
- Write request with `rst` low in cycle 2 → no `mem_write` pulse. A fresh read to the same address after reset gives the old value.
- `req_read` and `req_write` together at 1032, data 9 → a write is performed, and a later read of 1032 returns 9. Changing `req_addr` mid-access does not alter `mem_addr`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
// The index helper works in 64 bits so callers can use any ADDR_W up to 64.
`timescale 1ns/1ps
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, READ = 2'd1, WRITE = 2'd2} op_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 4;

  // Byte address to word index; the low two address bits drop out.
  function automatic logic [63:0] wordIndex(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: clear/enable up-counter, flags terminal count at WAIT_CYCLES-1.
`timescale 1ns/1ps
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic termCnt
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign termCnt = (cnt == CW'(WAIT_CYCLES - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: turns a held read/write request into a timed memory access,
// stalling the pipeline until DONE and returning registered read data.
`timescale 1ns/1ps
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef struct packed {
    op_t               op;
    logic              err;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t      state, nextState;
  acc_t        acc;
  logic        reqAny, reqInRange, termCnt, cntClr, cntEn;
  logic [63:0] reqIdx64;

  assign reqAny     = req_read | req_write;
  assign reqIdx64   = wordIndex(64'(req_addr), 64'(BASE_ADDR));
  assign reqInRange = (64'(req_addr) >= 64'(BASE_ADDR)) && (reqIdx64 < 64'(DEPTH));

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) uWaitCnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cntClr),
    .en      (cntEn),
    .termCnt (termCnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (reqAny) nextState = reqInRange ? ACCESS : DONE;
      ACCESS:  if (termCnt) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Memory-side signals come only from these latches, so stage inputs may move mid-access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '{op: NONE, err: 1'b0, idx: '0, wdata: '0};
      rdata <= '0;
    end else begin
      if (state == IDLE && reqAny) begin
        acc.op    <= req_write ? WRITE : READ;
        acc.err   <= !reqInRange;
        acc.idx   <= reqInRange ? ADDR_W'(reqIdx64) : '0;
        acc.wdata <= req_wdata;
        if (!reqInRange) rdata <= '0;
      end
      if (state == ACCESS && termCnt && acc.op == READ) rdata <= mem_rdata;
    end
  end

  always_comb begin
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_err  = 1'b0;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    unique case (state)
      IDLE: begin
        stall  = reqAny;
        cntClr = 1'b1;
      end
      ACCESS: begin
        stall     = reqAny;
        cntEn     = 1'b1;
        mem_read  = (acc.op == READ);
        // single strobe in the last wait cycle: one committed write per request
        mem_write = (acc.op == WRITE) && termCnt;
      end
      DONE:    addr_err = acc.err;
      default: ;
    endcase
  end

  assign mem_addr  = acc.idx;
  assign mem_wdata = acc.wdata;
endmodule
